// File: rtl/vrf_wb_pkg.sv
// Shared constants and entry layout for the vector register file write-back queue.
package vrf_wb_pkg;

  localparam int unsigned VLEN     = 128;
  localparam int unsigned NUM_VREG = 32;
  localparam int unsigned VREG_AW  = 5;
  localparam int unsigned MAX_GRP  = 4;
  localparam int unsigned STRB_W   = 16;

  typedef struct packed {
    logic [VREG_AW-1:0]                 base;
    logic                               lmul;
    logic [MAX_GRP-1:0][STRB_W-1:0]     wstrb;
    logic [MAX_GRP-1:0][VLEN-1:0]       wdata;
  } wb_entry_t;

  typedef enum logic {
    WB_IDLE,
    WB_DRAIN
  } wb_state_e;

endpackage

// File: rtl/vrf_wb_queue_if.sv
// Result-group handshake from the vector execute datapath into the write-back queue.
interface vrf_wb_queue_if;
  import vrf_wb_pkg::*;

  logic                           in_valid;
  logic                           in_ready;
  logic                           in_lmul;
  logic [VREG_AW-1:0]             in_waddr;
  logic [MAX_GRP-1:0][STRB_W-1:0] in_wstrb;
  logic [MAX_GRP-1:0][VLEN-1:0]   in_wdata;

  modport master (
    output in_valid, in_lmul, in_waddr, in_wstrb, in_wdata,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_lmul, in_waddr, in_wstrb, in_wdata,
    output in_ready
  );

endinterface

// File: rtl/vrf_wb_fifo.sv
// Group-entry storage for the write-back queue: pointers, occupancy and per-slot valid flags.
module vrf_wb_fifo
  import vrf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  wb_entry_t                    push_entry,
  input  logic                         pop,
  output wb_entry_t [DEPTH-1:0]        slot,
  output logic [DEPTH-1:0]             slot_valid,
  output logic [$clog2(DEPTH)-1:0]     head_idx,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [AW:0]           count_q;

  // Lanes 1-3 of a single-register group are never written into storage.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q].base     <= push_entry.base;
      mem_q[wr_ptr_q].lmul     <= push_entry.lmul;
      mem_q[wr_ptr_q].wstrb[0] <= push_entry.wstrb[0];
      mem_q[wr_ptr_q].wdata[0] <= push_entry.wdata[0];
      if (push_entry.lmul) begin
        for (int unsigned l = 1; l < MAX_GRP; l++) begin
          mem_q[wr_ptr_q].wstrb[2'(l)] <= push_entry.wstrb[2'(l)];
          mem_q[wr_ptr_q].wdata[2'(l)] <= push_entry.wdata[2'(l)];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_comb begin
    slot_valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      logic [AW-1:0] off;
      off           = AW'(i) - rd_ptr_q;
      slot_valid[i] = ({1'b0, off} < count_q);
    end
  end

  assign slot     = mem_q;
  assign head_idx = rd_ptr_q;
  assign count    = count_q;
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/vrf_wb_queue.sv
// Write-back queue: buffers 1- or 4-register result groups and drains them one register per cycle.
// Optional build macro VRF_WB_STRB_SKIP_EN skips lanes whose byte strobes are all zero.
module vrf_wb_queue
  import vrf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 vsi_clk,
  input  logic                 vsi_rst,
  vrf_wb_queue_if.slave        in_bus,
  output logic                 vsi_rf_we,
  output logic [VREG_AW-1:0]   vsi_rf_waddr,
  output logic [STRB_W-1:0]    vsi_rf_wstrb,
  output logic [VLEN-1:0]      vsi_rf_wdata,
  output logic [NUM_VREG-1:0]  pending_mask,
  output logic                 wb_idle
);

  localparam int unsigned AW = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0] slot;
  logic [DEPTH-1:0]      slot_valid;
  logic [AW-1:0]         head_idx;
  logic [AW:0]           count;
  logic [AW:0]           cnt_nxt;
  logic                  full;
  logic                  empty;
  wb_entry_t             push_entry;
  wb_entry_t             head;
  logic                  push;
  logic                  pop;
  logic                  drain;
  wb_state_e             state_q;
  logic [1:0]            sub_idx_q;
  logic [1:0]            cur;
  logic                  has_cur;
  logic                  more;

  function automatic logic lane_live(input wb_entry_t e, input logic [1:0] l);
`ifdef VRF_WB_STRB_SKIP_EN
    return (e.lmul || l == 2'd0) && (e.wstrb[l] != '0);
`else
    return (e.lmul || l == 2'd0);
`endif
  endfunction

  assign in_bus.in_ready = !full;
  assign push            = in_bus.in_valid && !full;

  always_comb begin
    push_entry       = '0;
    push_entry.base  = in_bus.in_waddr;
    push_entry.lmul  = in_bus.in_lmul;
    push_entry.wstrb = in_bus.in_wstrb;
    push_entry.wdata = in_bus.in_wdata;
  end

  vrf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (vsi_clk),
    .rst        (vsi_rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .slot       (slot),
    .slot_valid (slot_valid),
    .head_idx   (head_idx),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  assign head    = slot[head_idx];
  assign drain   = (state_q == WB_DRAIN);
  assign cnt_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
  assign wb_idle = empty;

  // Current lane is the first live lane at or after sub_idx; the head pops when no
  // live lane follows it. Without strobe skipping this reduces to cur == sub_idx.
  always_comb begin
    has_cur = 1'b0;
    cur     = '0;
    more    = 1'b0;
    for (int unsigned l = 0; l < MAX_GRP; l++) begin
      if (lane_live(head, 2'(l)) && 2'(l) >= sub_idx_q) begin
        if (!has_cur) begin
          has_cur = 1'b1;
          cur     = 2'(l);
        end else begin
          more = 1'b1;
        end
      end
    end
  end

  assign pop = drain && !more;

  always_ff @(posedge vsi_clk or posedge vsi_rst) begin
    if (vsi_rst) begin
      state_q   <= WB_IDLE;
      sub_idx_q <= '0;
    end else begin
      state_q <= (cnt_nxt != '0) ? WB_DRAIN : WB_IDLE;
      if (pop)        sub_idx_q <= '0;
      else if (drain) sub_idx_q <= cur + 2'd1;
    end
  end

  always_comb begin
    vsi_rf_we    = 1'b0;
    vsi_rf_waddr = '0;
    vsi_rf_wstrb = '0;
    vsi_rf_wdata = '0;
    if (drain && has_cur) begin
      vsi_rf_we    = 1'b1;
      vsi_rf_waddr = head.base + VREG_AW'(cur);
      vsi_rf_wstrb = head.wstrb[cur];
      vsi_rf_wdata = head.wdata[cur];
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned l = 0; l < MAX_GRP; l++) begin
        if (slot_valid[i] && lane_live(slot[i], 2'(l)) &&
            (AW'(i) != head_idx || 2'(l) >= sub_idx_q)) begin
          pending_mask[slot[i].base + VREG_AW'(l)] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vrf_wb_queue.sv
// Self-checking bench for vrf_wb_queue: directed table, corner sequences and randomized traffic.
module tb_vrf_wb_queue;
  import vrf_wb_pkg::*;

  localparam int unsigned DEPTH = 4;
`ifdef VRF_WB_STRB_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          we;
  logic [4:0]    waddr;
  logic [15:0]   wstrb;
  logic [127:0]  wdata;
  logic [31:0]   mask;
  logic          idle;

  vrf_wb_queue_if bus();

  vrf_wb_queue #(.DEPTH(DEPTH)) dut (
    .vsi_clk      (clk),
    .vsi_rst      (rst),
    .in_bus       (bus),
    .vsi_rf_we    (we),
    .vsi_rf_waddr (waddr),
    .vsi_rf_wstrb (wstrb),
    .vsi_rf_wdata (wdata),
    .pending_mask (mask),
    .wb_idle      (idle)
  );

  always #5 clk = ~clk;

  // Reference: the expected stream of register writes, plus writes left per queued group.
  typedef struct {
    logic [4:0]   a;
    logic [15:0]  s;
    logic [127:0] d;
  } wr_t;

  wr_t wq[$];
  int  grp_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int dut_writes  = 0;

  typedef struct {
    logic         v;
    logic         lmul;
    logic [4:0]   base;
    logic [127:0] dbase;
    logic         e_we;
    logic [4:0]   e_a;
    logic [127:0] e_d;
    logic [31:0]  e_m;
    logic         e_idle;
  } vec_t;

  vec_t tbl[15];

  function automatic void model_push(input logic lmul, input logic [4:0] base,
                                     input logic [3:0][15:0] s, input logic [3:0][127:0] d);
    int  n;
    int  nr;
    wr_t w;
    n  = 0;
    nr = lmul ? 4 : 1;
    for (int l = 0; l < nr; l++) begin
      if (SKIP && s[l] == 16'h0) continue;
      w.a = base + 5'(l);
      w.s = s[l];
      w.d = d[l];
      wq.push_back(w);
      n++;
    end
    grp_q.push_back(n);
  endfunction

  function automatic void model_edge();
    if (grp_q.size() != 0) begin
      if (grp_q[0] != 0) begin
        void'(wq.pop_front());
        grp_q[0] = grp_q[0] - 1;
      end
      if (grp_q[0] == 0) void'(grp_q.pop_front());
    end
  endfunction

  task automatic cmp(input string name, input logic e_we, input logic [4:0] e_a,
                     input logic [15:0] e_s, input logic [127:0] e_d, input logic [31:0] e_m,
                     input logic e_r, input logic e_i);
    vectors++;
    if (we) dut_writes++;
    if ({we, waddr, wstrb, wdata, mask, bus.in_ready, idle} !==
        {e_we, e_a, e_s, e_d, e_m, e_r, e_i}) begin
      miscompares++;
      $display("FAIL %s t=%0t: got we=%0b addr=%0d strb=%h data=%h mask=%h ready=%0b idle=%0b; want we=%0b addr=%0d strb=%h data=%h mask=%h ready=%0b idle=%0b",
               name, $time, we, waddr, wstrb, wdata, mask, bus.in_ready, idle,
               e_we, e_a, e_s, e_d, e_m, e_r, e_i);
    end
  endtask

  task automatic check_model(input string name);
    logic         e_we;
    wr_t          e;
    logic [31:0]  e_m;
    e_we = 1'b0;
    e.a = '0; e.s = '0; e.d = '0;
    e_m = '0;
    if (grp_q.size() != 0 && grp_q[0] != 0) begin
      e_we = 1'b1;
      e    = wq[0];
    end
    foreach (wq[i]) e_m[wq[i].a] = 1'b1;
    cmp(name, e_we, e.a, e.s, e.d, e_m, grp_q.size() < DEPTH, grp_q.size() == 0);
  endtask

  task automatic drive(input logic v, input logic lmul, input logic [4:0] base,
                       input logic [3:0][15:0] s, input logic [3:0][127:0] d);
    bus.in_valid = v;
    bus.in_lmul  = lmul;
    bus.in_waddr = base;
    bus.in_wstrb = s;
    bus.in_wdata = d;
  endtask

  task automatic advance();
    logic                push_e;
    logic                l;
    logic [4:0]          b;
    logic [3:0][15:0]    s;
    logic [3:0][127:0]   d;
    push_e = bus.in_valid && (grp_q.size() < DEPTH);
    l = bus.in_lmul; b = bus.in_waddr; s = bus.in_wstrb; d = bus.in_wdata;
    @(posedge clk);
    model_edge();
    if (push_e) model_push(l, b, s, d);
    #1;
  endtask

  task automatic step(input string name);
    check_model(name);
    advance();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0]      a5;
    logic [3:0][15:0]  s;
    logic [3:0][127:0] d;
    logic              accepted;

    a5 = {16{8'hA5}};
    drive(1'b0, 1'b0, 5'd0, '0, '0);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_model("reset");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Single write to vr5, a 4-register group at vr8, and a group wrapping past vr31.
    tbl[0]  = '{1'b1, 1'b0, 5'd5,  a5,         1'b0, 5'd0,  128'd0,     32'h0,        1'b1};
    tbl[1]  = '{1'b0, 1'b0, 5'd0,  128'd0,     1'b1, 5'd5,  a5,         32'h20,       1'b0};
    tbl[2]  = '{1'b0, 1'b0, 5'd0,  128'd0,     1'b0, 5'd0,  128'd0,     32'h0,        1'b1};
    tbl[3]  = '{1'b1, 1'b1, 5'd8,  128'd0,     1'b0, 5'd0,  128'd0,     32'h0,        1'b1};
    tbl[4]  = '{1'b0, 1'b0, 5'd0,  128'd0,     1'b1, 5'd8,  128'd0,     32'hF00,      1'b0};
    tbl[5]  = '{1'b0, 1'b0, 5'd0,  128'd0,     1'b1, 5'd9,  128'd1,     32'hE00,      1'b0};
    tbl[6]  = '{1'b0, 1'b0, 5'd0,  128'd0,     1'b1, 5'd10, 128'd2,     32'hC00,      1'b0};
    tbl[7]  = '{1'b0, 1'b0, 5'd0,  128'd0,     1'b1, 5'd11, 128'd3,     32'h800,      1'b0};
    tbl[8]  = '{1'b0, 1'b0, 5'd0,  128'd0,     1'b0, 5'd0,  128'd0,     32'h0,        1'b1};
    tbl[9]  = '{1'b1, 1'b1, 5'd30, 128'h100,   1'b0, 5'd0,  128'd0,     32'h0,        1'b1};
    tbl[10] = '{1'b0, 1'b0, 5'd0,  128'd0,     1'b1, 5'd30, 128'h100,   32'hC0000003, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 5'd0,  128'd0,     1'b1, 5'd31, 128'h101,   32'h80000003, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 5'd0,  128'd0,     1'b1, 5'd0,  128'h102,   32'h3,        1'b0};
    tbl[13] = '{1'b0, 1'b0, 5'd0,  128'd0,     1'b1, 5'd1,  128'h103,   32'h2,        1'b0};
    tbl[14] = '{1'b0, 1'b0, 5'd0,  128'd0,     1'b0, 5'd0,  128'd0,     32'h0,        1'b1};

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].lmul, tbl[i].base, {4{16'hFFFF}},
            {tbl[i].dbase + 128'd3, tbl[i].dbase + 128'd2, tbl[i].dbase + 128'd1, tbl[i].dbase});
      cmp($sformatf("table[%0d]", i), tbl[i].e_we, tbl[i].e_a,
          tbl[i].e_we ? 16'hFFFF : 16'h0000, tbl[i].e_d, tbl[i].e_m, 1'b1, tbl[i].e_idle);
      advance();
    end

    // Five back-to-back 4-register groups into a 4-deep queue.
    dut_writes = 0;
    for (int g = 0; g < 5; g++) begin
      drive(1'b1, 1'b1, 5'(4 * g), {4{16'hFFFF}}, {rnd128(), rnd128(), rnd128(), rnd128()});
      accepted = 1'b0;
      for (int c = 0; c < 50 && !accepted; c++) begin
        accepted = (grp_q.size() < DEPTH);
        step("full");
      end
      if (!accepted) begin
        vectors++;
        miscompares++;
        $display("FAIL full_accept: group %0d not accepted within 50 cycles, want accepted", g);
      end
    end
    drive(1'b0, 1'b0, 5'd0, '0, '0);
    repeat (24) step("full_drain");
    vectors++;
    if (dut_writes != 20) begin
      miscompares++;
      $display("FAIL full_writes: got %0d RF writes, want 20", dut_writes);
    end

    // Reset asserted during the second write of a 4-register group.
    drive(1'b1, 1'b1, 5'd12, {4{16'hFFFF}}, {rnd128(), rnd128(), rnd128(), rnd128()});
    step("rst_push");
    drive(1'b0, 1'b0, 5'd0, '0, '0);
    step("rst_lane0");
    check_model("rst_lane1");
    #2 rst = 1'b1;
    #1 cmp("rst_async", 1'b0, 5'd0, 16'h0, 128'd0, 32'h0, 1'b1, 1'b1);
    wq.delete();
    grp_q.delete();
    #1 rst = 1'b0;
    repeat (6) step("post_rst");

    // Zero-strobe lanes inside a group, then fully zero-strobe groups.
    drive(1'b1, 1'b1, 5'd4, {16'h00FF, 16'h0000, 16'h0000, 16'hFFFF},
          {rnd128(), rnd128(), rnd128(), rnd128()});
    step("strb_push");
    drive(1'b0, 1'b0, 5'd0, '0, '0);
    vectors++;
    if (mask !== (SKIP ? 32'h90 : 32'hF0)) begin
      miscompares++;
      $display("FAIL strb_mask: got %h want %h", mask, SKIP ? 32'h90 : 32'hF0);
    end
    repeat (6) step("strb_drain");
    drive(1'b1, 1'b1, 5'd20, '0, {rnd128(), rnd128(), rnd128(), rnd128()});
    step("zero_grp4");
    drive(1'b1, 1'b0, 5'd3, '0, {rnd128(), rnd128(), rnd128(), rnd128()});
    step("zero_grp1");
    drive(1'b0, 1'b0, 5'd0, '0, '0);
    repeat (8) step("zero_drain");

    // Randomized traffic against the write-stream model.
    for (int n = 0; n < 600; n++) begin
      for (int l = 0; l < 4; l++) begin
        s[l] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom());
        d[l] = rnd128();
      end
      drive($urandom_range(0, 3) != 0, 1'($urandom()), 5'($urandom()), s, d);
      step("rand");
    end
    drive(1'b0, 1'b0, 5'd0, '0, '0);
    repeat (24) step("rand_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vrf_wb_queue.md
Name: vrf_wb_queue

Overview:
- Write-back stage directly downstream of the vector execute datapath.
- Accepts one result group per handshake: 1 register (LMUL=1) or 4 registers (LMUL=4), each with 128-bit data and 16-bit byte strobes.
- Buffers groups in a small FIFO and drains them to the vector register file through a single write port, one register per cycle.
- Exports a 32-bit pending-write mask so the control unit can stall RAW/WAW hazards on queued destinations.

Parameters:
- DEPTH, 4, number of group entries in the FIFO; power of two, minimum 2.

Ports:
- vsi_clk  input  1  clock.
- vsi_rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  result group valid.
- in_ready  output  1  queue can accept a group.
- in_lmul  input  1  0 = 1 register, 1 = 4 registers.
- in_waddr  input  5  base destination register.
- in_wstrb  input  [3:0][15:0]  per-register byte strobes; index i targets in_waddr+i.
- in_wdata  input  [3:0][127:0]  per-register data.
- vsi_rf_we  output  1  RF write enable.
- vsi_rf_waddr  output  5  RF write address.
- vsi_rf_wstrb  output  16  RF byte strobes.
- vsi_rf_wdata  output  128  RF write data.
- pending_mask  output  32  bit r set while any queued write to vr r is outstanding.
- wb_idle  output  1  FIFO empty.

Behaviour:
- Reset (async, immediate): wr_ptr, rd_ptr, count and sub_idx are 0; FIFO storage is not reset.
  - Outputs under reset: vsi_rf_we=0, vsi_rf_waddr=0, vsi_rf_wstrb=0, vsi_rf_wdata=0, pending_mask=0, wb_idle=1, in_ready=1.
  - Reset mid-drain discards all queued groups, including the partially written head; no further writes occur.
- Accept:
  - in_ready = (count != DEPTH).
  - Push on in_valid && in_ready at the rising edge.
  - When in_lmul=0, lanes 1-3 of in_wstrb/in_wdata are ignored and not stored.
- Drain state machine: IDLE (count==0) and DRAIN (count!=0).
  - In DRAIN the RF outputs are combinational from the head entry and sub_idx:
    - vsi_rf_we=1
    - vsi_rf_waddr = (base + sub_idx) mod 32 (5-bit wrap; vr31 followed by vr0)
    - vsi_rf_wstrb / vsi_rf_wdata = lane sub_idx.
  - Each cycle in DRAIN: if sub_idx == nregs-1 (nregs = 1 or 4), pop the head and set sub_idx=0; otherwise sub_idx++.
  - In IDLE all RF outputs are 0.
- Latency: a group accepted at edge N gives its first vsi_rf_we in the cycle after edge N, if the queue was empty.
  - An LMUL=4 group occupies the port for 4 consecutive cycles.
  - There are no bubbles between back-to-back entries.
- Simultaneous push and pop: allowed; count stays unchanged.
  - A push is never accepted while full, even if a pop occurs the same cycle (no pass-through).
- pending_mask: combinational OR over all valid entries of their target registers.
  - For the head entry, only lanes sub_idx..nregs-1 contribute.
  - A register being written in the current cycle is still set; it clears after the edge that completes its write.
  - Duplicate targets across entries stay set until the last one drains.
- wb_idle = (count==0).
- No alignment check on in_waddr: an unaligned LMUL=4 base is written as-is with wrap.

Optional Feature:
- Macro: VRF_WB_STRB_SKIP_EN.
- Defined:
  - Lanes with wstrb==16'h0000 are skipped; the drain advances to the next lane with a non-zero strobe in the same cycle and uses no RF cycle for skipped lanes.
  - A group whose strobes are all zero is popped in one cycle with vsi_rf_we=0.
  - Zero-strobe lanes never set pending_mask.
- Undefined: every lane is written, including zero strobes (vsi_rf_we=1, wstrb=0), and every lane contributes to pending_mask.

Decomposition:
- Package vrf_wb_pkg contains:
  - constants VLEN=128, NUM_VREG=32, VREG_AW=5, MAX_GRP=4, STRB_W=16
  - typedef wb_entry_t {base, lmul, wstrb[4], wdata[4]}.
- One sub-module: vrf_wb_fifo, which holds entry storage, pointers, count and the full/empty flags.
- Drain sequencing and mask generation stay in vrf_wb_queue.

Test Plan:
- Single LMUL=0 push: waddr=5, wstrb=FFFF, wdata=A5…A5 → one cycle later, one write to vr5 with matching data; pending_mask bit5 high for exactly one cycle; wb_idle returns to 1.
- LMUL=4 push: base=8, lane data 0..3 → writes vr8, vr9, vr10, vr11 on 4 consecutive cycles; pending_mask goes 0xF00 → 0xE00 → 0xC00 → 0x800 → 0.
- Wrap: LMUL=4 push with base=30 → writes vr30, vr31, vr0, vr1 in that order.
- Full: DEPTH=4, push 5 LMUL=4 groups back-to-back → in_ready low after the 4th; 5th accepted only after the first group's 4th write; total of 20 writes in order with no gaps.
- Reset mid-drain: assert vsi_rst during the 2nd write of an LMUL=4 group → vsi_rf_we drops immediately; pending_mask=0, in_ready=1; no later writes.
- With VRF_WB_STRB_SKIP_EN: LMUL=4 push with lane strobes {FFFF,0,0,00FF} at base=4 → writes only vr4 and vr7, on 2 consecutive cycles; pending_mask starts at 0x90.
